pll_clk_sequencer: RTL and testbench

Power-up and recovery sequencer for the core PLL of the AE350 demo platform. Runs on the free-running 50 MHz board clock, drives the PLL's active-high reset, and qualifies its lock output with a synchronizer and a stability filter. It then opens the five gated PLL outputs (ENCLK0..4) one at a time in a fixed order, and tears everything down and re-locks on lock loss or a software restart request. It sits between the board clock/reset pins and the PLL instance; its `clk_ready` gates the SoC reset release.

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/lock_sync.sv | 22 ++
 rtl/pll_clk_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pll_clk_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL clock sequencer: FSM state encoding and
// default timing constants for the 50 MHz board clock.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_ENABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_e;

  localparam int DEF_NUM_CLK      = 5;
  localparam int DEF_RST_CYCLES   = 100;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_LOCK_STABLE  = 256;
  localparam int DEF_ENA_GAP      = 16;
  localparam int DEF_MAX_RETRY    = 3;

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock into the clkin domain.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both clear to "not locked" on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_clk_sequencer.sv
// Power-up / recovery sequencer for the core PLL: holds the PLL in reset,
// qualifies lock, opens the gated outputs one at a time and tears down on
// lock loss or a restart pulse. restart is a one-cycle pulse sampled directly
// on clkin and wins over every other event in the same cycle.
module pll_clk_sequencer
  import pll_seq_pkg::*;
#(
  parameter int                 NUM_CLK      = DEF_NUM_CLK,
  parameter logic [NUM_CLK-1:0] EN_MASK      = '1,
  parameter int                 RST_CYCLES   = DEF_RST_CYCLES,
  parameter int                 LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int                 LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int                 ENA_GAP      = DEF_ENA_GAP,
  parameter int                 MAX_RETRY    = DEF_MAX_RETRY,
  localparam int                RC_W         = $clog2(MAX_RETRY + 1)
) (
  input  logic               clkin,
  input  logic               reset_n,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_reset,
  output logic [NUM_CLK-1:0] enclk,
  output logic               clk_ready,
  output logic               pll_fail,
  output logic [RC_W-1:0]    retry_cnt,
  output logic [7:0]         lock_loss_cnt,
  output logic [2:0]         state
);

  localparam int PH_MAX = (RST_CYCLES > ENA_GAP) ? RST_CYCLES : ENA_GAP;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int SB_W   = $clog2(LOCK_STABLE + 1);

  pll_state_e         state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [TO_W-1:0]    tmo_q, tmo_d;
  logic [SB_W-1:0]    stab_q, stab_d;
  logic [NUM_CLK-1:0] enclk_d;
  logic [RC_W-1:0]    retry_d;
  logic [7:0]         loss_d;
  logic               lock_s;
  logic               tmo_hit;

  // Isolate the lowest set bit, used to pick the next output to open.
  function automatic logic [NUM_CLK-1:0] low_bit(input logic [NUM_CLK-1:0] v);
    return v & (~v + NUM_CLK'(1));
  endfunction

  lock_sync u_lock_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign state   = state_q;
  assign tmo_hit = (tmo_q >= TO_W'(LOCK_TIMEOUT - 1));

  // Next-state, counter and output decode; restart overrides every state.
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    enclk_d = '0;
    retry_d = retry_cnt;
    loss_d  = lock_loss_cnt;
    // Timeout runs through WAIT_LOCK and FILTER and saturates.
    tmo_d   = '0;
    if (state_q == ST_WAIT_LOCK || state_q == ST_FILTER) begin
      tmo_d = (&tmo_q) ? tmo_q : tmo_q + TO_W'(1);
    end
    stab_d  = '0;
    if (state_q == ST_FILTER && lock_s) begin
      stab_d = stab_q + SB_W'(1);
    end

    if (restart) begin
      state_d = ST_RST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST_HOLD: begin
          if (phase_q == PH_W'(RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_FILTER;
          end else if (tmo_hit) begin
            if (retry_cnt == RC_W'(MAX_RETRY)) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_cnt + RC_W'(1);
              state_d = ST_RST_HOLD;
            end
          end
        end
        ST_FILTER: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (stab_q == SB_W'(LOCK_STABLE - 1)) begin
            if (EN_MASK == '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_ENABLE;
              enclk_d = low_bit(EN_MASK);
            end
          end
        end
        ST_ENABLE: begin
          if (!lock_s) begin
            state_d = ST_RST_HOLD;
          end else if (phase_q == PH_W'(ENA_GAP - 1)) begin
            if (enclk == EN_MASK) begin
              state_d = ST_RUN;
              enclk_d = enclk;
            end else begin
              enclk_d = enclk | low_bit(EN_MASK & ~enclk);
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
            enclk_d = enclk;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RST_HOLD;
            if (lock_loss_cnt != 8'hFF) begin
              loss_d = lock_loss_cnt + 8'd1;
            end
          end else begin
            enclk_d = enclk;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RST_HOLD;
        end
      endcase
    end

    if (state_d == ST_RUN) begin
      retry_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RST_HOLD;
      phase_q       <= '0;
      tmo_q         <= '0;
      stab_q        <= '0;
      pll_reset     <= 1'b1;
      enclk         <= '0;
      clk_ready     <= 1'b0;
      pll_fail      <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      tmo_q         <= tmo_d;
      stab_q        <= stab_d;
      pll_reset     <= (state_d == ST_RST_HOLD) || (state_d == ST_FAIL);
      enclk         <= enclk_d;
      clk_ready     <= (state_d == ST_RUN);
      pll_fail      <= (state_d == ST_FAIL);
      retry_cnt     <= retry_d;
      lock_loss_cnt <= loss_d;
    end
  end

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Bench for pll_clk_sequencer with short timing parameters.
module tb_pll_clk_sequencer;

  localparam int         NUM_CLK = 5;
  localparam logic [4:0] EN_MASK = 5'b10111;
  localparam int         R_CYC   = 4;
  localparam int         T_OUT   = 20;
  localparam int         S_LEN   = 8;
  localparam int         G_GAP   = 3;
  localparam int         M_RETRY = 2;
  localparam int         RC_W    = $clog2(M_RETRY + 1);

  logic               clkin = 1'b0;
  logic               reset_n = 1'b0;
  logic               pll_lock = 1'b0;
  logic               restart = 1'b0;
  logic               pll_reset;
  logic [NUM_CLK-1:0] enclk;
  logic               clk_ready;
  logic               pll_fail;
  logic [RC_W-1:0]    retry_cnt;
  logic [7:0]         lock_loss_cnt;
  logic [2:0]         state;

  int n_cmp = 0;
  int n_bad = 0;
  int k_bits = 0;
  logic [NUM_CLK:0] exp_q[$];

  pll_clk_sequencer #(
    .NUM_CLK      (NUM_CLK),
    .EN_MASK      (EN_MASK),
    .RST_CYCLES   (R_CYC),
    .LOCK_TIMEOUT (T_OUT),
    .LOCK_STABLE  (S_LEN),
    .ENA_GAP      (G_GAP),
    .MAX_RETRY    (M_RETRY)
  ) dut (
    .clkin         (clkin),
    .reset_n       (reset_n),
    .pll_lock      (pll_lock),
    .restart       (restart),
    .pll_reset     (pll_reset),
    .enclk         (enclk),
    .clk_ready     (clk_ready),
    .pll_fail      (pll_fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  // ---------------- driver helpers ----------------
  // Ticks until pll_reset leaves level lvl (bounded); n = ticks taken.
  task automatic count_level(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (pll_reset === lvl && n < 200);
  endtask

  // ---------------- reference model ----------------
  // Expected {clk_ready, enclk} t cycles after pll_lock is raised in WAIT_LOCK:
  // lock_s rises 2 cycles later, first bit LOCK_STABLE+1 after that, then
  // one more mask bit (ascending) every ENA_GAP, ready ENA_GAP after the last.
  function automatic logic [NUM_CLK:0] ref_out(input int t);
    logic [NUM_CLK-1:0] m;
    logic [NUM_CLK-1:0] en;
    int r;
    int first;
    m = EN_MASK;
    en = '0;
    r = 0;
    first = S_LEN + 3;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (m[i]) begin
        if (t >= first + r * G_GAP) en[i] = 1'b1;
        r++;
      end
    end
    return {(t >= first + r * G_GAP), en};
  endfunction

  // Called right after pll_lock is raised; follows the whole bring-up.
  task automatic follow_bringup(input string tag);
    int span;
    logic [NUM_CLK:0] e;
    logic [NUM_CLK:0] a;
    span = S_LEN + 3 + k_bits * G_GAP + 2;
    exp_q.delete();
    for (int t = 1; t <= span; t++) exp_q.push_back(ref_out(t));
    for (int t = 1; t <= span; t++) begin
      tick();
      e = exp_q.pop_front();
      a = {clk_ready, enclk};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s t=%0d ready_enclk got %b want %b", tag, t, a, e);
      end
    end
    n_cmp++;
    if (retry_cnt !== '0) begin
      n_bad++;
      $display("FAIL %s retry_cnt got %0d want 0", tag, retry_cnt);
    end
  endtask

  // Bring the DUT from a fresh RST_HOLD entry up to RUN quickly.
  task automatic wait_ready(input string tag);
    int n;
    pll_lock = 1'b1;
    n = 0;
    while (clk_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (clk_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s clk_ready got %b want 1 within 200 cycles", tag, clk_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    pll_lock = 1'b0;
    restart = 1'b0;
    repeat (2) tick();
    n_cmp++; if (pll_reset !== 1'b1) begin n_bad++; $display("FAIL rst_pll_reset got %b want 1", pll_reset); end
    n_cmp++; if (enclk !== '0) begin n_bad++; $display("FAIL rst_enclk got %b want 0", enclk); end
    n_cmp++; if (clk_ready !== 1'b0) begin n_bad++; $display("FAIL rst_clk_ready got %b want 0", clk_ready); end
    n_cmp++; if (pll_fail !== 1'b0) begin n_bad++; $display("FAIL rst_pll_fail got %b want 0", pll_fail); end
    n_cmp++; if (retry_cnt !== '0) begin n_bad++; $display("FAIL rst_retry got %0d want 0", retry_cnt); end
    n_cmp++; if (lock_loss_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_loss got %0d want 0", lock_loss_cnt); end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", state); end
  endtask

  task automatic test_clean_bringup();
    int n;
    int d;
    for (int run = 0; run < 3; run++) begin
      do_reset();
      count_level(1'b1, n);
      n_cmp++; if (n != R_CYC) begin n_bad++; $display("FAIL clean_rst_pulse got %0d want %0d", n, R_CYC); end
      d = (run == 0) ? 5 : int'($urandom_range(1, 12));
      repeat (d) tick();
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL clean_wait_state got %0d want 1", state); end
      pll_lock = 1'b1;
      follow_bringup("clean");
      n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL clean_run_state got %0d want 4", state); end
    end
  endtask

  task automatic test_no_lock();
    int n;
    do_reset();
    for (int a = 0; a <= M_RETRY; a++) begin
      count_level(1'b1, n);
      n_cmp++; if (n != R_CYC) begin n_bad++; $display("FAIL nolock_rst_pulse a=%0d got %0d want %0d", a, n, R_CYC); end
      count_level(1'b0, n);
      n_cmp++; if (n != T_OUT) begin n_bad++; $display("FAIL nolock_timeout a=%0d got %0d want %0d", a, n, T_OUT); end
      if (a < M_RETRY) begin
        n_cmp++; if (retry_cnt !== RC_W'(a + 1)) begin n_bad++; $display("FAIL nolock_retry a=%0d got %0d want %0d", a, retry_cnt, a + 1); end
        n_cmp++; if (pll_fail !== 1'b0) begin n_bad++; $display("FAIL nolock_early_fail a=%0d got %b want 0", a, pll_fail); end
      end
    end
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL nolock_state got %0d want 5", state); end
    n_cmp++; if (pll_fail !== 1'b1) begin n_bad++; $display("FAIL nolock_pll_fail got %b want 1", pll_fail); end
    n_cmp++; if (retry_cnt !== RC_W'(M_RETRY)) begin n_bad++; $display("FAIL nolock_retry_final got %0d want %0d", retry_cnt, M_RETRY); end
    repeat (10) tick();
    n_cmp++; if (state !== 3'd5 || pll_reset !== 1'b1 || enclk !== '0) begin
      n_bad++; $display("FAIL nolock_hold state=%0d pll_reset=%b enclk=%b want 5/1/0", state, pll_reset, enclk);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++; if (pll_fail !== 1'b0) begin n_bad++; $display("FAIL restart_pll_fail got %b want 0", pll_fail); end
    n_cmp++; if (retry_cnt !== '0) begin n_bad++; $display("FAIL restart_retry got %0d want 0", retry_cnt); end
    n_cmp++; if (state !== 3'd0 || pll_reset !== 1'b1) begin n_bad++; $display("FAIL restart_state got %0d/%b want 0/1", state, pll_reset); end
    count_level(1'b1, n);
    n_cmp++; if (n != R_CYC) begin n_bad++; $display("FAIL restart_rst_pulse got %0d want %0d", n, R_CYC); end
    count_level(1'b0, n);
    n_cmp++; if (retry_cnt !== RC_W'(1)) begin n_bad++; $display("FAIL restart_retry_again got %0d want 1", retry_cnt); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++; if (retry_cnt !== '0) begin n_bad++; $display("FAIL restart_hold_retry got %0d want 0", retry_cnt); end
  endtask

  task automatic test_filter_glitch();
    int n;
    int d;
    int g;
    int elapsed;
    // Glitch then recovery: fresh stable window required.
    do_reset();
    count_level(1'b1, n);
    d = int'($urandom_range(1, 4));
    g = int'($urandom_range(2, 7));
    repeat (d) tick();
    pll_lock = 1'b1;
    repeat (g) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    follow_bringup("glitch");
    // Glitch then lock stays low: timeout counts from the original entry.
    do_reset();
    count_level(1'b1, n);
    d = int'($urandom_range(1, 4));
    g = int'($urandom_range(1, 7));
    elapsed = 0;
    repeat (d) tick();
    elapsed += d;
    pll_lock = 1'b1;
    repeat (g) tick();
    elapsed += g;
    pll_lock = 1'b0;
    repeat (3) tick();
    elapsed += 3;
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL glitch_back_state got %0d want 1", state); end
    count_level(1'b0, n);
    elapsed += n;
    n_cmp++; if (elapsed != T_OUT) begin n_bad++; $display("FAIL glitch_timeout got %0d want %0d", elapsed, T_OUT); end
    n_cmp++; if (retry_cnt !== RC_W'(1)) begin n_bad++; $display("FAIL glitch_retry got %0d want 1", retry_cnt); end
  endtask

  task automatic test_lock_loss();
    int n;
    int d;
    do_reset();
    count_level(1'b1, n);
    repeat (int'($urandom_range(1, 6))) tick();
    pll_lock = 1'b1;
    follow_bringup("pre_loss");
    repeat (int'($urandom_range(0, 5))) tick();
    pll_lock = 1'b0;
    tick();
    tick();
    n_cmp++; if (enclk !== EN_MASK) begin n_bad++; $display("FAIL loss_early got %b want %b", enclk, EN_MASK); end
    tick();
    n_cmp++; if (enclk !== '0 || clk_ready !== 1'b0) begin n_bad++; $display("FAIL loss_teardown enclk=%b ready=%b want 0/0", enclk, clk_ready); end
    n_cmp++; if (state !== 3'd0 || pll_reset !== 1'b1) begin n_bad++; $display("FAIL loss_state got %0d/%b want 0/1", state, pll_reset); end
    n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL loss_cnt got %0d want 1", lock_loss_cnt); end
    count_level(1'b1, n);
    n_cmp++; if (n != R_CYC) begin n_bad++; $display("FAIL loss_rst_pulse got %0d want %0d", n, R_CYC); end
    d = int'($urandom_range(1, 6));
    repeat (d) tick();
    pll_lock = 1'b1;
    follow_bringup("relock");
    // Loss during ENABLE tears down but is not counted.
    pll_lock = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    count_level(1'b1, n);
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (S_LEN + 3 + G_GAP) tick();
    n_cmp++; if (enclk !== 5'b00011) begin n_bad++; $display("FAIL enable_two_bits got %b want 00011", enclk); end
    pll_lock = 1'b0;
    repeat (3) tick();
    n_cmp++; if (state !== 3'd0 || enclk !== '0) begin n_bad++; $display("FAIL enable_loss state=%0d enclk=%b want 0/0", state, enclk); end
    n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL enable_loss_cnt got %0d want 1", lock_loss_cnt); end
  endtask

  task automatic test_restart_vs_loss();
    int n;
    do_reset();
    count_level(1'b1, n);
    wait_ready("rvl_up1");
    pll_lock = 1'b0;
    repeat (3) tick();
    wait_ready("rvl_up2");
    repeat (int'($urandom_range(0, 4))) tick();
    pll_lock = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++; if (state !== 3'd0 || pll_reset !== 1'b1) begin n_bad++; $display("FAIL rvl_state got %0d/%b want 0/1", state, pll_reset); end
    n_cmp++; if (enclk !== '0 || clk_ready !== 1'b0) begin n_bad++; $display("FAIL rvl_outputs enclk=%b ready=%b want 0/0", enclk, clk_ready); end
    n_cmp++; if (retry_cnt !== '0) begin n_bad++; $display("FAIL rvl_retry got %0d want 0", retry_cnt); end
    n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL rvl_loss_cnt got %0d want 1", lock_loss_cnt); end
    count_level(1'b1, n);
    n_cmp++; if (n != R_CYC) begin n_bad++; $display("FAIL rvl_rst_pulse got %0d want %0d", n, R_CYC); end
  endtask

  task automatic test_loss_saturation();
    int n;
    int exp_loss;
    do_reset();
    count_level(1'b1, n);
    exp_loss = 0;
    for (int i = 0; i < 258; i++) begin
      wait_ready("sat_up");
      if (clk_ready !== 1'b1) break;
      pll_lock = 1'b0;
      repeat (3) tick();
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      n_cmp++;
      if (lock_loss_cnt !== 8'(exp_loss)) begin
        n_bad++;
        $display("FAIL sat_loss_cnt i=%0d got %0d want %0d", i, lock_loss_cnt, exp_loss);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    count_level(1'b1, n);
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (S_LEN + 3 + G_GAP) tick();
    n_cmp++; if (enclk !== 5'b00011) begin n_bad++; $display("FAIL ar_pre_enclk got %b want 00011", enclk); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (enclk !== '0) begin n_bad++; $display("FAIL ar_enclk got %b want 0", enclk); end
    n_cmp++; if (pll_reset !== 1'b1) begin n_bad++; $display("FAIL ar_pll_reset got %b want 1", pll_reset); end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL ar_state got %0d want 0", state); end
    tick();
    reset_n = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    logic [NUM_CLK-1:0] m;
    m = EN_MASK;
    for (int i = 0; i < NUM_CLK; i++) if (m[i]) k_bits++;
    test_reset();
    test_clean_bringup();
    test_no_lock();
    test_filter_glitch();
    test_lock_loss();
    test_restart_vs_loss();
    test_loss_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
